// File: rtl/param_stack_pkg.sv
// Shared constants, count-width helper and op encoding for the parametrised LIFO.
package stack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Encoding is {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

endpackage

// File: rtl/param_stack_if.sv
// Request/status bundle between a stack user (master) and param_stack (slave).
interface param_stack_if
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = cw_of(DEPTH)
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] value_in;
    logic             clear_err;
    logic [WIDTH-1:0] value_out;
    logic             out_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, value_in, clear_err,
        input  value_out, out_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, value_in, clear_err,
        output value_out, out_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/param_stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we && waddr == CW'(i))
                mem[i] <= wdata;
        end
    end

    // Compare-and-select keeps out-of-range addresses (count-1 when empty) harmless.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (raddr == CW'(i))
                rdata = mem[i];
    end
endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with occupancy count, almost_full, push+pop swap/bypass and sticky errors.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic          clk,
    input  logic          reset,
    param_stack_if.slave  s
);
    localparam int CW = cw_of(DEPTH);

    logic [CW-1:0]    count_q, count_d, top_addr, waddr;
    logic [WIDTH-1:0] value_q, rdata;
    logic             vld_q, ovf_q, unf_q;
    logic             is_full, is_empty, we;
    logic             ovf_evt, unf_evt, out_upd;
    logic [WIDTH-1:0] out_d;
    op_e              op;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign top_addr = count_q - CW'(1);
    assign op       = op_e'({s.push, s.pop});

    always_comb begin
        count_d = count_q;
        we      = 1'b0;
        waddr   = count_q;
        out_upd = 1'b0;
        out_d   = rdata;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (op)
            OP_PUSH: begin
                if (is_full) ovf_evt = 1'b1;
                else begin
                    we      = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (is_empty) unf_evt = 1'b1;
                else begin
                    out_upd = 1'b1;
                    count_d = count_q - CW'(1);
                end
            end
            OP_SWAP: begin
                out_upd = 1'b1;
                // Empty: bypass straight through; otherwise replace the top in place.
                if (is_empty) out_d = s.value_in;
                else begin
                    we    = 1'b1;
                    waddr = top_addr;
                end
            end
            default: ;
        endcase
    end

    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_mem (
        .clk   (clk),
        .we    (we && reset),
        .waddr (waddr),
        .wdata (s.value_in),
        .raddr (top_addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            value_q <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            vld_q   <= out_upd;
            if (out_upd) value_q <= out_d;
            // Set wins over clear on the same edge.
            ovf_q <= ovf_evt | (ovf_q & ~s.clear_err);
            unf_q <= unf_evt | (unf_q & ~s.clear_err);
        end
    end

    assign s.count       = count_q;
    assign s.full        = is_full;
    assign s.empty       = is_empty;
    assign s.almost_full = (count_q >= CW'(AFULL_THRESH));
    assign s.value_out   = value_q;
    assign s.out_valid   = vld_q;
    assign s.overflow    = ovf_q;
    assign s.underflow   = unf_q;
endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack against a queue-based reference model.
module tb_param_stack;
    import stack_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = D - 2;
    localparam int CW = cw_of(D);
    localparam int VW = CW + 6 + W;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

    param_stack #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF)) u_dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus.slave)
    );

    // Reference model
    logic [W-1:0] q[$];
    logic [W-1:0] m_out;
    logic         m_vld, m_ovf, m_unf;

    function automatic logic [VW-1:0] exp_vec();
        int n = q.size();
        return {CW'(n), (n == D), (n == 0), (n >= AF), m_ovf, m_unf, m_vld, m_out};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.count, bus.full, bus.empty, bus.almost_full,
                bus.overflow, bus.underflow, bus.out_valid, bus.value_out};
    endfunction

    task automatic cycle(input logic p, input logic o, input logic [W-1:0] v, input logic clr);
        @(negedge clk);
        bus.push = p; bus.pop = o; bus.value_in = v; bus.clear_err = clr;
        @(posedge clk);
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        m_vld = 1'b0;
        if (p && o) begin
            m_vld = 1'b1;
            if (q.size() > 0) begin m_out = q[$]; q[$] = v; end
            else m_out = v;
        end else if (p) begin
            if (q.size() < D) q.push_back(v);
            else m_ovf = 1'b1;
        end else if (o) begin
            if (q.size() > 0) begin m_out = q.pop_back(); m_vld = 1'b1; end
            else m_unf = 1'b1;
        end
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clear_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        q.delete(); m_out = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.push = 1'b1; bus.pop = 1'b0; bus.value_in = 16'hDEAD; bus.clear_err = 1'b0;
        do_reset();
        bus.push = 1'b0;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
        end
        checks++;
        if ({bus.count, bus.empty, bus.value_out} !== {CW'(0), 1'b1, 16'h0000}) begin
            errors++; $display("FAIL reset_const count=%0d empty=%b vout=%h", bus.count, bus.empty, bus.value_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            cycle(1, 0, 16'h0013, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            checks++;
            if ({bus.count, bus.almost_full, bus.full, bus.overflow} !== {CW'(i), (i >= 6), (i == 8), 1'b0}) begin
                errors++; $display("FAIL fill_flags_%0d count=%0d af=%b full=%b ovf=%b", i,
                                   bus.count, bus.almost_full, bus.full, bus.overflow);
            end
        end
    endtask

    task automatic test_overflow();
        cycle(1, 0, 16'h0014, 0);
        checks++;
        if ({bus.count, bus.overflow} !== {CW'(8), 1'b1} || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL overflow_push got=%h exp=%h", dut_vec(), exp_vec());
        end
        cycle(0, 1, 16'h0000, 0);
        checks++;
        if ({bus.out_valid, bus.value_out} !== {1'b1, 16'h0013}) begin
            errors++; $display("FAIL overflow_pop vld=%b vout=%h exp=1/0013", bus.out_valid, bus.value_out);
        end
    endtask

    task automatic test_lifo();
        logic [W-1:0] exp_seq [3] = '{16'h0003, 16'h0002, 16'h0001};
        do_reset();
        for (int i = 1; i <= 3; i++) cycle(1, 0, W'(i), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 16'hxxxx, 0);
            checks++;
            if ({bus.out_valid, bus.value_out} !== {1'b1, exp_seq[i]} || dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL lifo_pop_%0d vld=%b vout=%h exp=%h", i, bus.out_valid, bus.value_out, exp_seq[i]);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got=%b exp=1", bus.empty); end
        cycle(0, 1, 16'h0000, 0);
        checks++;
        if ({bus.underflow, bus.value_out, bus.out_valid} !== {1'b1, 16'h0001, 1'b0}) begin
            errors++; $display("FAIL lifo_underflow unf=%b vout=%h vld=%b", bus.underflow, bus.value_out, bus.out_valid);
        end
    endtask

    task automatic test_swap();
        do_reset();
        cycle(1, 0, 16'h00AA, 0);
        cycle(1, 0, 16'h00BB, 0);
        cycle(1, 1, 16'h00CC, 0);
        checks++;
        if ({bus.value_out, bus.count, bus.out_valid} !== {16'h00BB, CW'(2), 1'b1}) begin
            errors++; $display("FAIL swap vout=%h count=%0d vld=%b", bus.value_out, bus.count, bus.out_valid);
        end
        cycle(0, 1, 16'h0000, 0);
        checks++;
        if (bus.value_out !== 16'h00CC) begin errors++; $display("FAIL swap_pop got=%h exp=00cc", bus.value_out); end
        while (q.size() < D) cycle(1, 0, W'($urandom), 0);
        cycle(1, 1, 16'h5A5A, 0);
        checks++;
        if ({bus.count, bus.overflow, bus.out_valid} !== {CW'(8), 1'b0, 1'b1} || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL swap_full got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_bypass();
        do_reset();
        cycle(1, 1, 16'h1234, 0);
        checks++;
        if ({bus.value_out, bus.out_valid, bus.count, bus.empty, bus.overflow, bus.underflow}
            !== {16'h1234, 1'b1, CW'(0), 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL bypass got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clear();
        do_reset();
        while (q.size() < D) cycle(1, 0, W'($urandom), 0);
        cycle(1, 0, 16'h0001, 0);
        cycle(1, 0, 16'h0002, 1);
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clear_setwins got=%b exp=1", bus.overflow); end
        cycle(0, 0, 16'h0000, 1);
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clear_alone got=%b exp=0", bus.overflow); end
        while (q.size() > 5) cycle(0, 1, 16'h0000, 0);
        checks++;
        if (bus.count !== CW'(5)) begin errors++; $display("FAIL clear_pre_reset count=%0d exp=5", bus.count); end
        do_reset();
        checks++;
        if ({bus.count, bus.value_out, bus.empty} !== {CW'(0), 16'h0000, 1'b1}) begin
            errors++; $display("FAIL mid_reset count=%0d vout=%h empty=%b", bus.count, bus.value_out, bus.empty);
        end
    endtask

    task automatic test_random();
        logic p, o;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 50);
            o = ($urandom_range(0, 99) < 40);
            cycle(p, o, (!p && o) ? 16'hxxxx : W'($urandom), ($urandom_range(0, 15) == 0));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.value_in = '0; bus.clear_err = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_lifo();
        test_swap();
        test_bypass();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
